mod3_stream: RTL
================

MOD3_STREAM -- requirements
Module: mod3_stream

Interface
REQ-001 Parameter DW, default 8: input word width; SHALL be even, 2..64; any other value is a configuration error.
REQ-002 Parameter ACCUM, default 0: 0 = one remainder per word; 1 = running remainder over a multi-word message, most significant word first.
REQ-003 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 Port dat_i, input, DW: input word.
REQ-006 Port valid_i, input, 1: dat_i/last_i valid.
REQ-007 Port last_i, input, 1: final word of message; ignored when ACCUM=0.
REQ-008 Port ready_o, output, 1: block accepts a beat this cycle.
REQ-009 Port reminder_o, output, 2: result remainder, 0..2.
REQ-010 Port beats_o, output, 16: word count of the message that produced reminder_o.
REQ-011 Port valid_o, output, 1: reminder_o/beats_o valid.
REQ-012 Port ready_i, input, 1: downstream accepts result.
REQ-013 Port busy_o, output, 1: a message is partially accumulated (ACCUM=1 only; tied 0 when ACCUM=0).

Function
REQ-014 Beat accepted iff valid_i && ready_o at clock edge; result transferred iff valid_o && ready_i.
REQ-015 ready_o SHALL equal !valid_o || ready_i; no combinational path from valid_i to ready_o.
REQ-016 Word remainder w = dat_i mod 3, computed by folding 2-bit digit pairs (digit weights +1/-1, since 4 mod 3 = 1); value 3 SHALL never appear on any internal or output remainder.
REQ-017 Running-remainder rule: r_next = (r + w) mod 3; valid because DW even gives 2^DW mod 3 = 1.
REQ-018 ACCUM=0: each accepted beat loads output register next edge: reminder_o = w, beats_o = 1, valid_o = 1; latency 1 cycle; full throughput (1 beat/cycle) while ready_i=1.
REQ-019 ACCUM=1 states: IDLE (acc=0, cnt=0, busy_o=0) and BUSY (busy_o=1).
REQ-020 ACCUM=1, accepted beat, last_i=0: acc <= (acc+w) mod 3; cnt <= cnt+1 saturating at 16'hFFFF; state -> BUSY; no output.
REQ-021 ACCUM=1, accepted beat, last_i=1: reminder_o <= (acc+w) mod 3, beats_o <= cnt+1 (saturating), valid_o <= 1; acc <= 0, cnt <= 0; state -> IDLE; latency 1 cycle from last beat.
REQ-022 Single-word message (last_i=1 in IDLE) SHALL give reminder_o = w, beats_o = 1.
REQ-023 Non-last beats SHALL be accepted whenever ready_o=1 and SHALL NOT modify valid_o or held output values.
REQ-024 Simultaneous output transfer and last-beat accept in same cycle: new result loaded, valid_o stays 1, no bubble, no loss.
REQ-025 Output transfer with no new result: valid_o <= 0 next edge.
REQ-026 While valid_o=1 and ready_i=0: reminder_o, beats_o, valid_o SHALL hold stable; ready_o=0; acc/cnt unchanged.
REQ-027 beats_o SHALL saturate at 16'hFFFF, never wrap; remainder still exact.

Reset
REQ-028 rst_i high asynchronously clears: valid_o=0, reminder_o=0, beats_o=0, acc=0, cnt=0, state IDLE, busy_o=0.
REQ-029 ready_o SHALL be 0 while rst_i=1; 1 on the first cycle after release.
REQ-030 Reset mid-message SHALL discard the partial message; next accepted word starts a new message.

Verification
REQ-031 DW=8, ACCUM=0, ready_i=1: dat_i 0xFF, 0x07, 0x05 on consecutive cycles -> reminder_o 0, 1, 2 on the three following cycles, beats_o=1, valid_o continuous.
REQ-032 DW=8, ACCUM=1: 0x01 (last=0), 0x00 (last=1) -> one result reminder_o=1 (256 mod 3), beats_o=2; busy_o=1 between beats.
REQ-033 Backpressure: ACCUM=0, ready_i=0 after first result for 3 cycles -> reminder_o/valid_o stable, ready_o=0, second beat held by source; released ready_i -> second result next cycle, none dropped or duplicated.
REQ-034 ACCUM=1, rst_i pulsed after 2 non-last beats of 0x02 -> all outputs 0, busy_o=0; then 0x04 (last=1) -> reminder_o=1, beats_o=1.
REQ-035 DW=16, ACCUM=1, 70000 words 0x0001 with last on final -> beats_o=16'hFFFF, reminder_o = 70000 mod 3 = 1.
REQ-036 Random DW in {2,8,16,64}, both ACCUM values, random valid_i/ready_i: every result matches reference big-integer mod 3; no value 3 ever observed.

Source files
------------

// File: rtl/mod3_stream.sv
// Streaming remainder-mod-3 engine: per-word remainder, or a running remainder
// over a multi-word message (MS word first) with a 1-deep result register.
module mod3_stream #(
  parameter int DW    = 8,
  parameter int ACCUM = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] dat_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic          ready_o,
  output logic [1:0]    reminder_o,
  output logic [15:0]   beats_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o
);

  generate
    if (DW < 2 || DW > 64 || (DW % 2) != 0) begin : g_cfg_err
      $error("mod3_stream: DW must be even and within 2..64");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Sum of two residues, result kept in 0..2.
  function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // A 2-bit digit has bit weights +1/-1 mod 3, so only 3 folds to 0.
  function automatic logic [1:0] dig3(input logic [1:0] d);
    return (d == 2'd3) ? 2'd0 : d;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_acc, w_acc_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_valid;
  logic [1:0]  r_rem;
  logic [15:0] r_beats;

  logic [1:0]  w_word;
  logic [1:0]  w_sum;
  logic [15:0] w_cnt_inc;
  logic        w_accept;
  logic        w_last;
  logic        w_load;

  // Every pair has weight 4^k = 1 mod 3, so the word residue is the residue sum of its digits.
  always_comb begin
    w_word = 2'd0;
    for (int i = 0; i < DW / 2; i++) w_word = add3(w_word, dig3(dat_i[2*i +: 2]));
  end

  assign ready_o   = !rst_i && (!r_valid || ready_i);
  assign w_accept  = valid_i && ready_o;
  assign w_last    = (ACCUM == 0) ? 1'b1 : last_i;
  assign w_sum     = add3(r_acc, w_word);
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign busy_o    = (ACCUM != 0) && (r_state == S_BUSY);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    if (w_accept) begin
      if (w_last) begin
        w_load      = 1'b1;
        w_acc_nxt   = 2'd0;
        w_cnt_nxt   = 16'd0;
        w_state_nxt = S_IDLE;
      end else begin
        w_acc_nxt   = w_sum;
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = S_BUSY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_acc   <= 2'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A new result may replace one being transferred in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_rem   <= 2'd0;
      r_beats <= 16'd0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_rem   <= w_sum;
      r_beats <= w_cnt_inc;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o    = r_valid;
  assign reminder_o = r_rem;
  assign beats_o    = r_beats;

endmodule
